// File: rtl/branch_pred_pkg.sv
// Shared types and default sizing for the branch update queue.
package branch_pred_pkg;

  localparam int unsigned PC_W     = 32;
  localparam int unsigned BQ_DEPTH = 8;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            pred;
  } bq_entry_t;

endpackage

// File: rtl/bq_storage.sv
// Entry register array: one synchronous write port, one asynchronous read port.
module bq_storage
  import branch_pred_pkg::*;
#(
  parameter int unsigned DEPTH = BQ_DEPTH,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  bq_entry_t     wdata,
  input  logic [AW-1:0] raddr,
  output bq_entry_t     rdata
);

  bq_entry_t mem [DEPTH];

  // Entries need no reset: validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/branch_update_queue.sv
// In-order queue of predicted branches; drives predictor updates and mispredict flushes
// on resolution, and keeps saturating branch/mispredict statistics.
module branch_update_queue #(
  parameter int unsigned DEPTH  = branch_pred_pkg::BQ_DEPTH,
  parameter int unsigned PC_W   = branch_pred_pkg::PC_W,
  parameter int unsigned STAT_W = 16,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [PC_W-1:0]   push_pc,
  input  logic              push_pred,
  output logic              push_ready,
  input  logic              resolve,
  input  logic              resolve_taken,
  input  logic              flush,
  output logic              upd_ld,
  output logic              upd_br_en,
  output logic [PC_W-1:0]   upd_pc,
  output logic              mispredict,
  output logic [CW-1:0]     count,
  output logic              empty,
  output logic              full,
  output logic              resolve_err,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispred
);

  localparam int unsigned AW = $clog2(DEPTH);

  branch_pred_pkg::bq_entry_t wr_entry;
  branch_pred_pkg::bq_entry_t rd_entry;

  logic [AW:0]   head_q, head_d;
  logic [AW:0]   tail_q, tail_d;
  logic [CW-1:0] count_d;
  logic          clear;
  logic          res_ok;
  logic          mis_now;
  logic          push_ok;

  assign empty      = (head_q == tail_q);
  assign full       = (head_q[AW-1:0] == tail_q[AW-1:0]) && (head_q[AW] != tail_q[AW]);
  assign push_ready = !full;

  // A registered mispredict means every remaining entry is wrong-path.
  assign clear   = flush || mispredict;
  assign res_ok  = resolve && !empty;
  assign mis_now = res_ok && (resolve_taken != rd_entry.pred);
  assign push_ok = push && !full && !clear && !mis_now;

  assign wr_entry = '{pc: branch_pred_pkg::PC_W'(push_pc), pred: push_pred};

  bq_storage #(
    .DEPTH (DEPTH)
  ) u_storage (
    .clk   (clk),
    .we    (push_ok),
    .waddr (tail_q[AW-1:0]),
    .wdata (wr_entry),
    .raddr (head_q[AW-1:0]),
    .rdata (rd_entry)
  );

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count;
    if (clear) begin
      head_d  = tail_q;
      count_d = '0;
    end else begin
      if (push_ok) tail_d = tail_q + (AW+1)'(1);
      if (res_ok)  head_d = head_q + (AW+1)'(1);
      count_d = count + CW'(push_ok) - CW'(res_ok);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q        <= '0;
      tail_q        <= '0;
      count         <= '0;
      upd_ld        <= 1'b0;
      upd_br_en     <= 1'b0;
      upd_pc        <= '0;
      mispredict    <= 1'b0;
      resolve_err   <= 1'b0;
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count       <= count_d;
      upd_ld      <= res_ok;
      mispredict  <= mis_now;
      resolve_err <= resolve && empty;
      if (res_ok) begin
        upd_br_en <= resolve_taken;
        upd_pc    <= PC_W'(rd_entry.pc);
      end
      if (res_ok && (stat_branches != '1)) stat_branches <= stat_branches + 1'b1;
      if (mis_now && (stat_mispred != '1)) stat_mispred <= stat_mispred + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_update_queue.sv
// Directed bench for branch_update_queue with a scoreboard-driven update monitor.
module tb_branch_update_queue;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned PC_W   = 32;
  localparam int unsigned STAT_W = 4;
  localparam int unsigned CW     = $clog2(DEPTH + 1);

  logic              clk;
  logic              rst;
  logic              push;
  logic [PC_W-1:0]   push_pc;
  logic              push_pred;
  logic              push_ready;
  logic              resolve;
  logic              resolve_taken;
  logic              flush;
  logic              upd_ld;
  logic              upd_br_en;
  logic [PC_W-1:0]   upd_pc;
  logic              mispredict;
  logic [CW-1:0]     count;
  logic              empty;
  logic              full;
  logic              resolve_err;
  logic [STAT_W-1:0] stat_branches;
  logic [STAT_W-1:0] stat_mispred;

  typedef struct {
    logic [31:0] pc;
    logic        br;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   err_pending = 0;
  int   checks      = 0;
  int   failures    = 0;

  branch_update_queue #(
    .DEPTH  (DEPTH),
    .PC_W   (PC_W),
    .STAT_W (STAT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .push          (push),
    .push_pc       (push_pc),
    .push_pred     (push_pred),
    .push_ready    (push_ready),
    .resolve       (resolve),
    .resolve_taken (resolve_taken),
    .flush         (flush),
    .upd_ld        (upd_ld),
    .upd_br_en     (upd_br_en),
    .upd_pc        (upd_pc),
    .mispredict    (mispredict),
    .count         (count),
    .empty         (empty),
    .full          (full),
    .resolve_err   (resolve_err),
    .stat_branches (stat_branches),
    .stat_mispred  (stat_mispred)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Applies one cycle of stimulus; returns 1 time unit after the clock edge.
  task automatic cyc(input logic p, input logic [31:0] pc, input logic pr,
                     input logic r, input logic tk, input logic f);
    push = p; push_pc = pc; push_pred = pr;
    resolve = r; resolve_taken = tk; flush = f;
    @(posedge clk);
    #1;
    push = 1'b0; push_pc = '0; push_pred = 1'b0;
    resolve = 1'b0; resolve_taken = 1'b0; flush = 1'b0;
  endtask

  task automatic expect_upd(input logic [31:0] pc, input logic br, input logic mis);
    exp_t e;
    e.pc = pc; e.br = br; e.mis = mis;
    exp_q.push_back(e);
  endtask

  // Monitor: every update strobe must match the oldest scoreboard entry.
  always @(negedge clk) begin
    if (!rst) begin
      if (upd_ld) begin
        check("upd_ld_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("upd_pc", 64'(upd_pc), 64'(mon_e.pc));
          check("upd_br_en", 64'(upd_br_en), 64'(mon_e.br));
          check("mispredict", 64'(mispredict), 64'(mon_e.mis));
        end
      end else begin
        check("mispredict_idle", 64'(mispredict), 64'd0);
      end
      if (resolve_err) begin
        check("resolve_err_expected", 64'(err_pending != 0), 64'd1);
        if (err_pending > 0) err_pending--;
      end
    end
  end

  initial begin
    rst = 1'b1;
    push = 1'b0; push_pc = '0; push_pred = 1'b0;
    resolve = 1'b0; resolve_taken = 1'b0; flush = 1'b0;
    #12;
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_push_ready", 64'(push_ready), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_upd_ld", 64'(upd_ld), 64'd0);
    check("rst_stat_branches", 64'(stat_branches), 64'd0);
    check("rst_stat_mispred", 64'(stat_mispred), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Two correctly predicted branches.
    cyc(1, 32'h100, 1, 0, 0, 0);
    cyc(1, 32'h104, 0, 0, 0, 0);
    check("two_push_count", 64'(count), 64'd2);
    expect_upd(32'h100, 1, 0);
    cyc(0, 0, 0, 1, 1, 0);
    expect_upd(32'h104, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    check("two_res_count", 64'(count), 64'd0);
    check("two_res_empty", 64'(empty), 64'd1);
    check("two_res_stat_branches", 64'(stat_branches), 64'd2);
    check("two_res_stat_mispred", 64'(stat_mispred), 64'd0);

    // Fill, overflow push dropped, drain across the pointer wrap.
    for (int i = 0; i < 8; i++) cyc(1, 32'h300 + 32'(4 * i), i[0], 0, 0, 0);
    check("fill_full", 64'(full), 64'd1);
    check("fill_push_ready", 64'(push_ready), 64'd0);
    check("fill_count", 64'(count), 64'd8);
    cyc(1, 32'h200, 1, 0, 0, 0);
    check("overflow_count", 64'(count), 64'd8);
    check("overflow_full", 64'(full), 64'd1);
    for (int i = 0; i < 8; i++) begin
      expect_upd(32'h300 + 32'(4 * i), i[0], 0);
      cyc(0, 0, 0, 1, i[0], 0);
    end
    check("drain_count", 64'(count), 64'd0);
    check("drain_empty", 64'(empty), 64'd1);
    check("drain_stat_branches", 64'(stat_branches), 64'd10);

    // Mispredict recovery: same-cycle and recovery-cycle pushes are discarded.
    cyc(1, 32'h400, 1, 0, 0, 0);
    cyc(1, 32'h404, 1, 0, 0, 0);
    cyc(1, 32'h408, 0, 0, 0, 0);
    check("mis_pre_count", 64'(count), 64'd3);
    expect_upd(32'h400, 0, 1);
    cyc(1, 32'h40c, 0, 1, 0, 0);
    check("mis_res_count", 64'(count), 64'd2);
    cyc(1, 32'h410, 1, 0, 0, 0);
    check("mis_rec_count", 64'(count), 64'd0);
    check("mis_rec_empty", 64'(empty), 64'd1);
    check("mis_stat_mispred", 64'(stat_mispred), 64'd1);
    check("mis_stat_branches", 64'(stat_branches), 64'd11);

    // Resolve on empty, then simultaneous push+resolve cases.
    err_pending++;
    cyc(0, 0, 0, 1, 1, 0);
    check("err_stat_branches", 64'(stat_branches), 64'd11);
    check("err_stat_mispred", 64'(stat_mispred), 64'd1);
    check("err_count", 64'(count), 64'd0);
    err_pending++;
    cyc(1, 32'h500, 0, 1, 1, 0);
    check("empty_pushres_count", 64'(count), 64'd1);
    cyc(1, 32'h504, 1, 0, 0, 0);
    expect_upd(32'h500, 0, 0);
    cyc(1, 32'h508, 0, 1, 0, 0);
    check("pushres_count", 64'(count), 64'd2);
    expect_upd(32'h504, 1, 0);
    cyc(0, 0, 0, 1, 1, 0);
    expect_upd(32'h508, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    check("pushres_drain_count", 64'(count), 64'd0);
    check("pushres_stat_branches", 64'(stat_branches), 64'd14);

    // External flush: resolve still processed, push discarded, queue cleared.
    cyc(1, 32'h700, 1, 0, 0, 0);
    cyc(1, 32'h704, 1, 0, 0, 0);
    expect_upd(32'h700, 1, 0);
    cyc(1, 32'h708, 1, 1, 1, 1);
    check("flush_count", 64'(count), 64'd0);
    check("flush_empty", 64'(empty), 64'd1);
    check("flush_stat_branches", 64'(stat_branches), 64'd15);
    err_pending++;
    cyc(0, 0, 0, 1, 1, 0);

    // Saturation of both counters at 4'hF.
    for (int i = 0; i < 15; i++) begin
      cyc(1, 32'h600 + 32'(4 * i), 1, 0, 0, 0);
      expect_upd(32'h600 + 32'(4 * i), 0, 1);
      cyc(0, 0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
    end
    check("sat_stat_mispred", 64'(stat_mispred), 64'd15);
    check("sat_stat_branches", 64'(stat_branches), 64'd15);

    // Async reset right after a mispredicting resolve edge.
    cyc(1, 32'h800, 1, 0, 0, 0);
    cyc(1, 32'h804, 1, 0, 0, 0);
    resolve = 1'b1; resolve_taken = 1'b0;
    @(posedge clk);
    #1;
    resolve = 1'b0;
    check("pre_rst_upd_ld", 64'(upd_ld), 64'd1);
    rst = 1'b1;
    #1;
    check("arst_upd_ld", 64'(upd_ld), 64'd0);
    check("arst_mispredict", 64'(mispredict), 64'd0);
    check("arst_count", 64'(count), 64'd0);
    check("arst_empty", 64'(empty), 64'd1);
    check("arst_push_ready", 64'(push_ready), 64'd1);
    check("arst_stat_branches", 64'(stat_branches), 64'd0);
    check("arst_stat_mispred", 64'(stat_mispred), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cyc(1, 32'h900, 1, 0, 0, 0);
    check("post_rst_count", 64'(count), 64'd1);
    expect_upd(32'h900, 1, 0);
    cyc(0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    check("resolve_err_drained", 64'(err_pending), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_update_queue.md
Name: branch_update_queue

Overview:
- In-order FIFO tracking every conditional branch the fetch stage has predicted, from fetch to resolution in execute.
- At fetch: pushes {pc, predicted direction}.
- At execute resolution: pops head, compares actual vs predicted, drives the global predictor update interface (load strobe, actual direction, PC) and a mispredict flush pulse.
- Sits directly upstream of the global branch predictor's update port; also keeps saturating branch/mispredict statistics.

Parameters:
- DEPTH, 8, number of in-flight branch entries (power of two, >=2).
- PC_W, 32, stored PC width.
- STAT_W, 16, width of statistics counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- push  in  1  fetch predicted a conditional branch this cycle.
- push_pc  in  PC_W  PC of pushed branch.
- push_pred  in  1  predicted direction (1 = taken).
- push_ready  out  1  queue can accept a push (= !full).
- resolve  in  1  execute resolved the oldest branch this cycle.
- resolve_taken  in  1  actual direction.
- flush  in  1  external pipeline flush; discards all entries.
- upd_ld  out  1  one-cycle predictor update strobe.
- upd_br_en  out  1  actual direction for the update.
- upd_pc  out  PC_W  PC of resolved branch.
- mispredict  out  1  one-cycle pulse, resolved direction != predicted.
- count  out  $clog2(DEPTH+1)  occupied entries.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- resolve_err  out  1  one-cycle pulse, resolve seen while empty.
- stat_branches  out  STAT_W  saturating count of accepted resolves.
- stat_mispred  out  STAT_W  saturating count of mispredicts.

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0 except empty=1 and push_ready=1.
  - Head/tail pointers 0; stats 0.
- Storage: circular buffer of bq_entry_t {pc, pred}, with head and tail pointers of $clog2(DEPTH) bits plus a wrap bit. full/empty are derived from pointers; count is registered.
- Push: accepted when push && !full. Entry written at tail; tail increments, wrapping DEPTH-1 -> 0. A push while full is silently dropped, with no state change.
- Resolve: accepted when resolve && !empty. Head entry is read and head increments.
  - Next cycle (1-cycle latency, registered outputs): upd_ld=1, upd_br_en=resolve_taken, upd_pc=entry.pc, mispredict=(resolve_taken != entry.pred).
  - Otherwise upd_ld, mispredict and resolve_err are 0 the next cycle.
- Resolve while empty: ignored; resolve_err=1 the next cycle; no update and no stat change.
- Push and resolve in the same cycle:
  - Both take effect and count is unchanged.
  - When empty, the resolve does not bypass the same-cycle push: resolve_err pulses and the push is stored.
  - When full, the push is still dropped (push_ready governs) even though a pop occurs.
- Mispredict recovery: every entry younger than the mispredicted one is wrong-path.
  - In the cycle after a mispredicting resolve, the queue is cleared (head=tail, count=0).
  - Any push in that same cycle is discarded.
  - A push in the resolve cycle itself is also discarded, because the whole queue is cleared.
- flush: same clear as mispredict recovery, applied in the cycle flush is high.
  - A resolve in that cycle is still processed: update outputs are produced and stats are counted.
  - A push in that cycle is discarded.
- Stats:
  - stat_branches increments on each accepted resolve; stat_mispred increments on each mispredict.
  - Both saturate at all-ones; no wrap.
- Async reset mid-operation: all entries are discarded and any pending upd_ld or mispredict pulse is suppressed.

Decomposition:
- Package branch_pred_pkg holds:
  - bq_entry_t packed struct {logic [PC_W-1:0] pc; logic pred;} with PC_W as a package constant of 32.
  - The default DEPTH constant.
- Sub-module bq_storage: DEPTH x entry register array, with one write port (we, waddr, wdata) and one asynchronous read port (raddr -> rdata).
- Pointer, count, update and stats logic live in the top module.

Test Plan:
- Reset then idle -> empty=1, push_ready=1, count=0, upd_ld=0, stats=0.
- Push pc 0x100 pred=1, 0x104 pred=0; resolve taken=1, then taken=0 -> two upd_ld pulses with upd_pc 0x100/0x104 and upd_br_en 1/0, mispredict=0, stat_branches=2, count back to 0.
- Push 8 entries, then a 9th (0x200) -> full=1, push_ready=0, 9th dropped. Then 8 resolves return PCs in push order with correct pointer wrap.
- Push 3, resolve head with taken != pred -> mispredict=1 and upd_ld=1 the next cycle, count=0 afterwards, stat_mispred=1. A push asserted in the recovery cycle is discarded.
- Resolve on empty -> resolve_err pulse, no upd_ld, stats unchanged. Same-cycle push+resolve at count=2 -> count stays 2 and head advances.
- Preload stat_mispred near max via 2^STAT_W-1 mispredicts (STAT_W=4 build) -> counter holds at 15. Assert rst mid-stream -> outputs return to reset values immediately, with no clock edge needed.
